// File: rtl/systolic_array_core_if.sv
// ----------------------------------------------------------------------------
// systolic_array_core_if
//   Job-control, operand-stream and result-stream bundle for systolic_array_core.
//
//   master : the job owner (operand DMA + result writer side); drives start,
//            k_len, in_valid, a_col, b_row and c_ready.
//   slave  : the systolic engine; drives busy, done, in_ready, c_valid,
//            c_row_idx and c_out.
//
//   start/k_len        job request, sampled only while the engine is idle
//   busy/done          engine activity and end-of-job pulse
//   in_valid/in_ready  operand beat handshake; a_col slice i = A[i][k],
//                      b_row slice j = B[k][j]
//   c_valid/c_ready    result row handshake; c_out slice j = C[c_row_idx][j]
// ----------------------------------------------------------------------------
interface systolic_array_core_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int K_MAX      = 64
) ();
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic                    start;
  logic [KW-1:0]           k_len;
  logic                    busy;
  logic                    done;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] a_col;
  logic [M*DATA_WIDTH-1:0] b_row;
  logic                    c_valid;
  logic                    c_ready;
  logic [RW-1:0]           c_row_idx;
  logic [M*ACC_WIDTH-1:0]  c_out;

  modport master (
    output start, k_len, in_valid, a_col, b_row, c_ready,
    input  busy, done, in_ready, c_valid, c_row_idx, c_out
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, c_ready,
    output busy, done, in_ready, c_valid, c_row_idx, c_out
  );
endinterface

// File: rtl/systolic_array_core.sv
// ----------------------------------------------------------------------------
// systolic_array_core
//   N x M output-stationary systolic engine computing C = A x B, where A is
//   N x K and B is K x M with K chosen per job (clamped to K_MAX).
//
//   Operands arrive one k-step per accepted beat (A column, B row). Each row of
//   A and each column of B passes through an input skew chain, then marches
//   right/down through the PE grid; every PE multiplies what it sees and adds
//   into its own accumulator. After K beats the array is flushed with zeros
//   for N+M-1 steps, then C is drained one row per accepted c_valid/c_ready.
//
// Ports
//   clk   clock
//   rst   synchronous active-low reset
//   bus   systolic_array_core_if.slave (job control, operand and result streams)
// ----------------------------------------------------------------------------
module systolic_array_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int K_MAX      = 64
) (
  input  logic                clk,
  input  logic                rst,
  systolic_array_core_if.slave bus
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(N + M);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN
  } state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] beat_q;
  logic [FW-1:0] flush_q;
  logic [RW-1:0] row_q;
  logic          busy_q;
  logic          in_ready_q;
  logic          c_valid_q;

  logic [KW-1:0] k_clamped_d;
  logic          step;
  logic          clear;
  logic          last_row_ack;

  // Data paths between grid cells: a_bus[i][j] / b_bus[i][j] is what PE(i,j)
  // sees this step; column 0 / row 0 come from the skew chains.
  logic [N-1:0][M-1:0][DATA_WIDTH-1:0] a_bus;
  logic [N-1:0][M-1:0][DATA_WIDTH-1:0] b_bus;
  logic [N-1:0][M-1:0][ACC_WIDTH-1:0]  acc_bus;
  logic [N-1:0][DATA_WIDTH-1:0]        feed_a;
  logic [M-1:0][DATA_WIDTH-1:0]        feed_b;

  assign k_clamped_d  = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  // The whole array advances together: on an accepted beat while loading,
  // and unconditionally while flushing. A stalled beat freezes everything.
  assign step         = ((state_q == S_LOAD) && bus.in_valid) || (state_q == S_FLUSH);
  assign clear        = (state_q == S_IDLE) && bus.start;
  assign last_row_ack = (state_q == S_DRAIN) && bus.c_ready && (row_q == RW'(N - 1));

  // Zeros enter the array edges during FLUSH.
  assign feed_a = (state_q == S_LOAD) ? bus.a_col : '0;
  assign feed_b = (state_q == S_LOAD) ? bus.b_row : '0;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of statement order.
      state_q    <= S_IDLE;
      k_q        <= '0;
      beat_q     <= '0;
      flush_q    <= '0;
      row_q      <= '0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      c_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            k_q    <= k_clamped_d;
            beat_q <= '0;
            busy_q <= 1'b1;
            if (k_clamped_d == '0) begin
              // Nothing to accumulate: the cleared accumulators are the result.
              state_q   <= S_DRAIN;
              c_valid_q <= 1'b1;
            end else begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            beat_q <= beat_q + KW'(1);
            if (beat_q == k_q - KW'(1)) begin
              state_q    <= S_FLUSH;
              in_ready_q <= 1'b0;
              flush_q    <= '0;
            end
          end
        end
        S_FLUSH: begin
          flush_q <= flush_q + FW'(1);
          // Last product reaches PE(N-1,M-1) on step K+N+M-2.
          if (flush_q == FW'(N + M - 2)) begin
            state_q   <= S_DRAIN;
            c_valid_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.c_ready) begin
            if (row_q == RW'(N - 1)) begin
              state_q   <= S_IDLE;
              row_q     <= '0;
              c_valid_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Input skew. Row i of A and column j of B get i+1 / j+1 register stages:
  // the common first stage registers the beat, the remaining i / j stages are
  // the relative skew that lines up A[i][k] with B[k][j] at PE(i,j) on step
  // k+i+j+1.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_a_skew
    logic [DATA_WIDTH-1:0] chain_q [0:i];
    always_ff @(posedge clk) begin
      if (!rst || clear) begin
        // NOTE: small register arrays are cleared element by element here
        // because a stale skew value would leak into the next job; large
        // storage arrays would normally be left without reset.
        for (int s = 0; s <= i; s++) chain_q[s] <= '0;
      end else if (step) begin
        chain_q[0] <= feed_a[i];
        for (int s = 1; s <= i; s++) chain_q[s] <= chain_q[s-1];
      end
    end
    assign a_bus[i][0] = chain_q[i];
  end

  for (genvar j = 0; j < M; j++) begin : g_b_skew
    logic [DATA_WIDTH-1:0] chain_q [0:j];
    always_ff @(posedge clk) begin
      if (!rst || clear) begin
        for (int s = 0; s <= j; s++) chain_q[s] <= '0;
      end else if (step) begin
        chain_q[0] <= feed_b[j];
        for (int s = 1; s <= j; s++) chain_q[s] <= chain_q[s-1];
      end
    end
    assign b_bus[0][j] = chain_q[j];
  end

  // --------------------------------------------------------------------------
  // PE grid. A values move right, B values move down, one cell per step.
  // The last column / row have nowhere to forward, so they keep no pass
  // register.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < M; j++) begin : g_col
      logic signed [DATA_WIDTH-1:0]   a_in;
      logic signed [DATA_WIDTH-1:0]   b_in;
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]    acc_q;

      assign a_in = $signed(a_bus[i][j]);
      assign b_in = $signed(b_bus[i][j]);
      assign prod = a_in * b_in;

      // Sign-extended product; the sum wraps modulo 2^ACC_WIDTH.
      always_ff @(posedge clk) begin
        if (!rst || clear) begin
          acc_q <= '0;
        end else if (step) begin
          acc_q <= acc_q + ACC_WIDTH'(prod);
        end
      end
      assign acc_bus[i][j] = acc_q;

      if (j < M - 1) begin : g_a_pass
        logic [DATA_WIDTH-1:0] a_q;
        always_ff @(posedge clk) begin
          if (!rst || clear) begin
            a_q <= '0;
          end else if (step) begin
            a_q <= a_bus[i][j];
          end
        end
        assign a_bus[i][j+1] = a_q;
      end

      if (i < N - 1) begin : g_b_pass
        logic [DATA_WIDTH-1:0] b_q;
        always_ff @(posedge clk) begin
          if (!rst || clear) begin
            b_q <= '0;
          end else if (step) begin
            b_q <= b_bus[i][j];
          end
        end
        assign b_bus[i+1][j] = b_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.c_valid   = c_valid_q;
  assign bus.c_row_idx = row_q;
  assign bus.done      = last_row_ack;
  assign bus.c_out     = c_valid_q ? acc_bus[row_q] : '0;

endmodule
